// File: rtl/addr_key_seq.sv
// Read-access key sequencer: a window of read strobes carries key nibbles that unlock
// a response LFSR, which then answers each qualified read with one registered bit.
module addr_key_seq #(
  parameter int                 STATE_W   = 6,
  parameter int                 NUM_KEYS  = 4,
  parameter logic [31:0]        KEY_SEQ   = 32'h0000_A5C3,
  parameter logic [1:0]         WIN_BASE  = 2'b01,
  parameter logic [STATE_W-1:0] LFSR_SEED = 6'h2D,
  parameter logic [STATE_W-1:0] LFSR_TAPS = 6'h30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sel_n,
  input  logic [13:0] ba,
  input  logic        br_w,
  input  logic        strobe,
  output logic        sdrd,
  output logic        sdrd_oe,
  output logic        unlocked,
  output logic [2:0]  key_idx
);

  typedef enum logic [1:0] {
    S_LOCKED,
    S_MATCHING,
    S_UNLOCKED
  } state_t;

  localparam logic [3:0] NUM_KEYS_C = 4'(NUM_KEYS);

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [STATE_W-1:0]   lfsr_q, lfsr_d;
  logic [STATE_W-1:0]   lfsr_raw, lfsr_shift;
  logic                 sdrd_q, sdrd_d;
  logic                 qual, qual_d, step;
  logic [3:0]           nib;
  logic                 unused_ba;

  function automatic logic [3:0] key_nib(input logic [3:0] i);
    return 4'(KEY_SEQ >> {i, 2'b00});
  endfunction

  // Nibble repeated across the LFSR width; equals {nib, nib} truncated for widths up to 8.
  function automatic logic [STATE_W-1:0] nib_pattern(input logic [3:0] n);
    logic [STATE_W-1:0] p;
    for (int i = 0; i < STATE_W; i++) p[i] = n[2'(i % 4)];
    return p;
  endfunction

  assign nib       = ba[7:4];
  assign unused_ba = ^{ba[11:8], ba[3:0]};

  assign qual    = ~sel_n & (ba[13:12] == WIN_BASE) & br_w & strobe;
  assign step    = qual & ~qual_d;
  assign sdrd_oe = qual & qual_d;

  // A zero LFSR would never leave zero again, so reseed instead.
  assign lfsr_raw   = {lfsr_q[STATE_W-2:0], ^(lfsr_q & LFSR_TAPS) ^ nib[0]};
  assign lfsr_shift = (lfsr_raw == '0) ? LFSR_SEED : lfsr_raw;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    sdrd_d  = sdrd_q;
    if (step) begin
      sdrd_d = 1'b0;
      unique case (state_q)
        S_LOCKED: begin
          if (nib == key_nib(4'd0)) begin
            cnt_d = 4'd1;
            if (NUM_KEYS > 1) begin
              state_d = S_MATCHING;
            end else begin
              state_d = S_UNLOCKED;
              lfsr_d  = LFSR_SEED;
            end
          end else begin
            cnt_d = 4'd0;
          end
        end
        S_MATCHING: begin
          if (nib == key_nib(cnt_q)) begin
            cnt_d = cnt_q + 4'd1;
            if ((cnt_q + 4'd1) == NUM_KEYS_C) begin
              state_d = S_UNLOCKED;
              lfsr_d  = LFSR_SEED;
            end
          end else if (nib == key_nib(4'd0)) begin
            cnt_d = 4'd1;
          end else begin
            state_d = S_LOCKED;
            cnt_d   = 4'd0;
          end
        end
        S_UNLOCKED: begin
          if (nib == 4'hF) begin
            state_d = S_LOCKED;
            cnt_d   = 4'd0;
          end else begin
            lfsr_d = lfsr_shift;
            sdrd_d = ^(lfsr_shift & nib_pattern(nib));
          end
        end
        default: begin
          state_d = S_LOCKED;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  // qual_d only clears when the strobe drops, so non-qualifying cycles mid-access cannot re-arm a step.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_LOCKED;
      cnt_q   <= 4'd0;
      lfsr_q  <= LFSR_SEED;
      sdrd_q  <= 1'b0;
      qual_d  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      sdrd_q  <= sdrd_d;
      if (!strobe)   qual_d <= 1'b0;
      else if (qual) qual_d <= 1'b1;
    end
  end

  assign sdrd     = sdrd_q;
  assign unlocked = (state_q == S_UNLOCKED);
  assign key_idx  = cnt_q[2:0];

endmodule

// File: tb/tb_addr_key_seq.sv
// Scoreboard bench for addr_key_seq: a reference model pushes expected outputs per access,
// popped and compared once the access has been clocked into the DUT.
module tb_addr_key_seq;

  logic        clk = 1'b0;
  logic        rst_n, sel_n, br_w, strobe;
  logic [13:0] ba;
  logic        sdrd, sdrd_oe, unlocked;
  logic [2:0]  key_idx;

  addr_key_seq dut (
    .clk(clk), .rst_n(rst_n), .sel_n(sel_n), .ba(ba), .br_w(br_w), .strobe(strobe),
    .sdrd(sdrd), .sdrd_oe(sdrd_oe), .unlocked(unlocked), .key_idx(key_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       unl;
    logic [2:0] idx;
    logic       sd;
    logic [5:0] lf;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model state: 0 locked, 1 matching, 2 unlocked
  int         m_state;
  int         m_idx;
  logic [5:0] m_lfsr;
  logic       m_sdrd;
  logic [3:0] keys [4] = '{4'h3, 4'hC, 4'h5, 4'hA};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_idx = 0; m_lfsr = 6'h2D; m_sdrd = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] n);
    logic [5:0] nx;
    m_sdrd = 1'b0;
    case (m_state)
      0: if (n == keys[0]) begin m_idx = 1; m_state = 1; end else m_idx = 0;
      1: begin
        if (n == keys[m_idx]) begin
          m_idx++;
          if (m_idx == 4) begin m_state = 2; m_lfsr = 6'h2D; end
        end else if (n == keys[0]) m_idx = 1;
        else begin m_state = 0; m_idx = 0; end
      end
      default: begin
        if (n == 4'hF) begin m_state = 0; m_idx = 0; end
        else begin
          nx = {m_lfsr[4:0], m_lfsr[5] ^ m_lfsr[4] ^ n[0]};
          if (nx == 6'h00) nx = 6'h2D;
          m_lfsr = nx;
          m_sdrd = ^(nx & {n[1:0], n});
        end
      end
    endcase
  endtask

  task automatic push_exp();
    exp_t e;
    e.unl = (m_state == 2);
    e.idx = 3'(m_idx);
    e.sd  = m_sdrd;
    e.lf  = m_lfsr;
    sb.push_back(e);
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("unlocked", unlocked, e.unl);
      check("key_idx", key_idx, e.idx);
      check("sdrd", sdrd, e.sd);
      check("lfsr", dut.lfsr_q, e.lf);
    end
  endtask

  // One bus access held for len cycles; returns at a falling edge with the bus idle.
  task automatic bus(input logic [3:0] n, input logic rd, input logic sel_ok,
                     input logic win_ok, input int len);
    logic stepping;
    stepping = rd & sel_ok & win_ok;
    @(negedge clk);
    sel_n  = ~sel_ok;
    br_w   = rd;
    strobe = 1'b1;
    ba     = {(win_ok ? 2'b01 : 2'b10), 4'h0, n, 4'h0};
    if (stepping) model_step(n);
    push_exp();
    for (int c = 0; c < len; c++) begin
      check("sdrd_oe", sdrd_oe, (stepping && c > 0));
      @(posedge clk);
      @(negedge clk);
      if (c == 0) compare_out();
    end
    strobe = 1'b0;
    sel_n  = 1'b1;
    br_w   = 1'b0;
  endtask

  task automatic rd(input logic [3:0] n);
    bus(n, 1'b1, 1'b1, 1'b1, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; sel_n = 1'b1; br_w = 1'b0; strobe = 1'b0; ba = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_unlocked", unlocked, 1'b0);
    check("rst_key_idx", key_idx, 3'd0);
    check("rst_sdrd", sdrd, 1'b0);
    check("rst_lfsr", dut.lfsr_q, 6'h2D);
    check("rst_oe", sdrd_oe, 1'b0);

    // Full key, then lock again with F
    rd(4'h3); rd(4'hC); rd(4'h5); rd(4'hA);
    check("unlock_seq", unlocked, 1'b1);
    rd(4'hF);

    // Broken sequence, then restart on nibble 0
    rd(4'h3); rd(4'hC); rd(4'h7);
    rd(4'h3); rd(4'h3); rd(4'hC); rd(4'h5); rd(4'hA);

    // Non-qualifying accesses must not step
    bus(4'hF, 1'b0, 1'b1, 1'b1, 2);
    bus(4'hF, 1'b1, 1'b0, 1'b1, 2);
    bus(4'hF, 1'b1, 1'b1, 1'b0, 2);
    check("still_unlocked", unlocked, 1'b1);

    for (int i = 0; i < 10; i++) begin
      rd(4'h0);
      check("lfsr_nonzero", (dut.lfsr_q != 6'h00), 1'b1);
    end
    for (int i = 0; i < 20; i++) rd(4'($urandom_range(0, 14)));
    rd(4'hF);

    // Long strobe: one step only, output enable from the second cycle
    bus(4'h3, 1'b1, 1'b1, 1'b1, 5);
    rd(4'hC);
    check("mid_key_idx", key_idx, 3'd2);

    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check("mrst_key_idx", key_idx, 3'd0);
    check("mrst_unlocked", unlocked, 1'b0);
    check("mrst_sdrd", sdrd, 1'b0);

    // Access already qualified while reset is asserted steps once after release
    @(negedge clk);
    rst_n = 1'b0; sel_n = 1'b0; br_w = 1'b1; strobe = 1'b1; ba = {2'b01, 4'h0, 4'h3, 4'h0};
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rel_oe", sdrd_oe, 1'b0);
    model_step(4'h3);
    push_exp();
    @(posedge clk);
    @(negedge clk);
    compare_out();
    check("rel_oe_hold", sdrd_oe, 1'b1);
    strobe = 1'b0; sel_n = 1'b1; br_w = 1'b0;
    @(negedge clk);

    check("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/addr_key_seq.md
ADDR_KEY_SEQ -- requirements
Module: addr_key_seq

Interface
REQ-001 Parameter STATE_W, default 6, width of response LFSR (range 4..16).
REQ-002 Parameter NUM_KEYS, default 4, number of key nibbles in the unlock sequence (range 1..8).
REQ-003 Parameter KEY_SEQ, default 16'hA5C3, key nibbles packed LSB-first, NUM_KEYS*4 bits used.
REQ-004 Parameter WIN_BASE, default 2'b01, required value of {ba[13],ba[12]} for a window hit.
REQ-005 Parameter LFSR_SEED, default 6'h2D, LFSR load value on unlock, STATE_W bits, SHALL be nonzero.
REQ-006 Parameter LFSR_TAPS, default 6'h30, feedback tap mask, STATE_W bits.
REQ-007 clk  in  1  single clock; all state changes on rising edge.
REQ-008 rst_n  in  1  synchronous, active-low reset.
REQ-009 sel_n  in  1  active-low chip select.
REQ-010 ba  in  14  bus address; ba[13:12] window decode, ba[7:4] key/command nibble.
REQ-011 br_w  in  1  1 = read cycle; writes are ignored.
REQ-012 strobe  in  1  bus access valid; may stay high several cycles per access.
REQ-013 sdrd  out  1  response data bit, registered.
REQ-014 sdrd_oe  out  1  drive enable for sdrd, combinational.
REQ-015 unlocked  out  1  high in UNLOCKED state.
REQ-016 key_idx  out  3  number of key nibbles matched so far.

Function
REQ-017 qual = ~sel_n & ({ba[13],ba[12]}==WIN_BASE) & br_w & strobe.
REQ-018 step SHALL be asserted for exactly one cycle on the first cycle of qual after a cycle with qual low (rising-edge detect via registered qual_d).
REQ-019 All state changes occur only on cycles with step high; otherwise state holds.
REQ-020 States: LOCKED, MATCHING, UNLOCKED.
REQ-021 LOCKED: step with ba[7:4]==KEY_SEQ nibble 0 -> key_idx=1; MATCHING if NUM_KEYS>1, else UNLOCKED; else remain, key_idx=0.
REQ-022 MATCHING: step with nibble == KEY_SEQ[key_idx] -> key_idx+1; on reaching NUM_KEYS -> UNLOCKED, key_idx=NUM_KEYS.
REQ-023 MATCHING mismatch: if nibble == KEY_SEQ nibble 0, key_idx=1, stay MATCHING; else LOCKED, key_idx=0.
REQ-024 Entering UNLOCKED SHALL load lfsr <= LFSR_SEED in the same edge.
REQ-025 UNLOCKED: step with nibble 4'hF -> LOCKED, key_idx=0, lfsr held.
REQ-026 UNLOCKED: step with any other nibble -> lfsr <= {lfsr[STATE_W-2:0], ^(lfsr & LFSR_TAPS) ^ nibble[0]}.
REQ-027 sdrd SHALL update on every step edge to ^(lfsr_next & {nibble, nibble}) truncated to STATE_W bits in UNLOCKED, and to 0 in LOCKED/MATCHING; latency one cycle after step.
REQ-028 sdrd_oe = qual & ~qual_first, where qual_first = step; sdrd_oe is low on the step cycle and high thereafter while qual stays high.
REQ-029 If lfsr_next would be all-zero, lfsr SHALL load LFSR_SEED instead (lock-up avoidance).
REQ-030 Writes (br_w=0), deselected or out-of-window accesses SHALL neither step nor clear qual_d.

Reset
REQ-031 rst_n low at a clock edge: state=LOCKED, key_idx=0, lfsr=LFSR_SEED, sdrd=0, qual_d=0; unlocked=0.
REQ-032 Reset has priority over step in the same cycle; an access in progress at reset release is not stepped until qual falls and rises again... except qual_d=0 after reset, so a qual high at release SHALL produce one step.

Verification
REQ-033 Defaults; reads with nibbles A,5,C,3 (KEY_SEQ order 3,C,5,A per LSB-first: send 3,C,5,A) -> unlocked=1 after fourth step, key_idx=4, lfsr=6'h2D.
REQ-034 Sequence 3,C,7 -> LOCKED, key_idx=0; sequence 3,3,C,5,A -> unlocked=1 (restart on nibble 0).
REQ-035 strobe held high 5 cycles with valid key nibble -> exactly one step; sdrd_oe high cycles 2..5.
REQ-036 Unlocked, nibble 4'hF read -> unlocked=0 next cycle, sdrd=0; write cycle with nibble 4'hF -> no change.
REQ-037 Unlocked, 10 steps nibble 0 -> lfsr matches reference LFSR model each step, never 0.
REQ-038 rst_n low mid-MATCHING (key_idx=2) -> key_idx=0, LOCKED, sdrd=0 next edge.
